mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one 32-bit synchronous bus port between the IF stage (instruction fetch) and the MEM stage (load/store).
- Latches the winning request and runs a req/ack transaction with a bounded wait.
- Returns read data to the winning stage and raises per-stage stall requests to the pipeline stall controller until that stage's access completes.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- MAX_WAIT, 15, bus cycles without ack before the access is aborted; legal range 1..255

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, valid while if_done=1
- if_done  out  1  one-cycle completion pulse for fetch
- if_stallreq  out  1  stall request from fetch
- mem_req  in  1  data request, held until mem_done
- mem_we  in  1  1 = store, 0 = load
- mem_sel  in  4  byte enables
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  DATA_W  store data
- mem_rdata  out  DATA_W  load data, valid while mem_done=1
- mem_done  out  1  one-cycle completion pulse for data
- mem_stallreq  out  1  stall request from MEM
- bus_req  out  1  bus cycle request
- bus_we  out  1  bus write enable
- bus_sel  out  4  bus byte enables
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_rdata  in  DATA_W  bus read data, sampled when bus_ack=1
- bus_ack  in  1  bus completion, single cycle
- bus_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (rst=0, asynchronous), taking effect immediately:
  - state=IDLE.
  - Outputs cleared: bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_rdata, mem_rdata, if_done, mem_done, bus_err all 0.
  - Internal state cleared: wait counter=0, last_grant=IF.
- A reset mid-transaction drops bus_req at once. The in-flight access is discarded and no done pulse is issued.
- States:
  - IDLE: no bus activity.
  - IF_BUS: fetch access in progress on the bus.
  - MEM_BUS: data access in progress on the bus.
  - DONE: one-cycle completion state.
- IDLE arbitration:
  - Only mem_req set: go to MEM_BUS.
  - Only if_req set: go to IF_BUS.
  - Both set: MEM wins unless last_grant=MEM, in which case IF wins. This alternation prevents fetch starvation.
  - Neither set: stay in IDLE.
- Grant edge:
  - Register the winner's addr into bus_addr, we into bus_we, sel into bus_sel, wdata into bus_wdata.
  - Fetch drives bus_we=0, bus_sel=4'hF, bus_wdata=0.
  - Set bus_req=1 and last_grant=winner.
  - bus_* stay stable until the transaction ends; later changes on the requester's inputs are ignored.
- *_BUS states:
  - Wait counter increments each cycle bus_ack=0.
  - bus_ack=1: capture bus_rdata into the winner's rdata register, bus_req=0, go to DONE.
  - Counter reaches MAX_WAIT with no ack: bus_req=0, rdata register=0, bus_err=1 for one cycle, go to DONE.
  - Ack arriving on the same cycle as the timeout counts as success: no bus_err.
- DONE:
  - Winner's done=1 for exactly this cycle.
  - Counter=0.
  - Next state is IDLE. There is no direct re-grant, so there is one idle bus cycle between transactions.
- Latency: an uncontended access with ack on the first bus cycle gives done 2 cycles after the request is sampled in IDLE.
- Stall requests are combinational:
  - if_stallreq = if_req & ~if_done.
  - mem_stallreq = mem_req & ~mem_done.
  - The pipeline stall controller sees the stall drop in the DONE cycle, and the stage advances on the following edge.
- rdata registers hold their value until the next completion for the same stage.
- bus_ack received outside *_BUS states is ignored.
- A requester dropping its req mid-transaction does not abort the transaction. It completes and done still pulses.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0100, ack on 2nd bus cycle with rdata=0x2402_0005. Required: bus_addr=0x100, bus_we=0, bus_sel=F; if_done pulses once; if_rdata=0x24020005; if_stallreq=1 until the DONE cycle.
- Store:
  - Stimulus: mem_req=1, mem_we=1, mem_sel=4'b0011, mem_addr=0x80, mem_wdata=0xDEADBEEF, immediate ack.
  - Required: bus mirrors these values; mem_done pulses 2 cycles after the request; if_stallreq is unaffected.
- Contention: if_req and mem_req both held high from reset release. Required: grant order is MEM, IF, MEM, IF; each done pulse is separated by at least 2 cycles.
- Timeout with MAX_WAIT=3: mem_req load, no ack. Required: bus_req high for 3 cycles, then bus_err=1 for one cycle, mem_done=1, mem_rdata=0, then IDLE.
- Ack on the timeout cycle (MAX_WAIT=3): ack arrives on the 3rd wait cycle with rdata=0x1234. Required: rdata=0x1234, bus_err stays 0.
- Reset mid-access: rst asserted low while in MEM_BUS. Required: bus_req=0 immediately, no mem_done pulse, last_grant=IF, and after release a simultaneous request is granted to MEM.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, the shared bus port and the arbiter.
// The master modport is the arbiter's view; the slave modport is the pipeline/bus environment's view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stallreq;

    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_stallreq;

    logic              bus_req;
    logic              bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;
    logic              bus_err;

    modport master (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        input  bus_rdata, bus_ack,
        output if_rdata, if_done, if_stallreq, mem_rdata, mem_done, mem_stallreq,
        output bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );

    modport slave (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
        output bus_rdata, bus_ack,
        input  if_rdata, if_done, if_stallreq, mem_rdata, mem_done, mem_stallreq,
        input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one synchronous bus port between instruction fetch and load/store,
// with round-robin on contention, a bounded ack wait and per-stage stall requests.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.master   bus
);

    localparam int unsigned    CNT_W   = 8;
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_IF_BUS  = 2'd1,
        S_MEM_BUS = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e            r_state,     w_state;
    logic [CNT_W-1:0]  r_cnt,       w_cnt;
    logic              r_last_mem,  w_last_mem;
    logic              r_bus_req,   w_bus_req;
    logic              r_bus_we,    w_bus_we;
    logic [3:0]        r_bus_sel,   w_bus_sel;
    logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata;
    logic [DATA_W-1:0] r_if_rdata,  w_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata, w_mem_rdata;
    logic              r_if_done,   w_if_done;
    logic              r_mem_done,  w_mem_done;
    logic              r_bus_err,   w_bus_err;
    logic              w_grant_mem;

    // MEM wins a tie unless it won last time, so fetch cannot starve.
    assign w_grant_mem = bus.mem_req & (~bus.if_req | ~r_last_mem);

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_last_mem  = r_last_mem;
        w_bus_req   = r_bus_req;
        w_bus_we    = r_bus_we;
        w_bus_sel   = r_bus_sel;
        w_bus_addr  = r_bus_addr;
        w_bus_wdata = r_bus_wdata;
        w_if_rdata  = r_if_rdata;
        w_mem_rdata = r_mem_rdata;
        w_if_done   = 1'b0;
        w_mem_done  = 1'b0;
        w_bus_err   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.mem_req | bus.if_req) begin
                    w_bus_req  = 1'b1;
                    w_cnt      = '0;
                    w_last_mem = w_grant_mem;
                    if (w_grant_mem) begin
                        w_state     = S_MEM_BUS;
                        w_bus_we    = bus.mem_we;
                        w_bus_sel   = bus.mem_sel;
                        w_bus_addr  = bus.mem_addr;
                        w_bus_wdata = bus.mem_wdata;
                    end else begin
                        w_state     = S_IF_BUS;
                        w_bus_we    = 1'b0;
                        w_bus_sel   = 4'hF;
                        w_bus_addr  = bus.if_addr;
                        w_bus_wdata = '0;
                    end
                end
            end
            S_IF_BUS, S_MEM_BUS: begin
                // An ack on the final wait cycle takes priority over the timeout.
                if (bus.bus_ack) begin
                    w_bus_req = 1'b0;
                    w_state   = S_DONE;
                    if (r_state == S_MEM_BUS) begin
                        w_mem_rdata = bus.bus_rdata;
                        w_mem_done  = 1'b1;
                    end else begin
                        w_if_rdata  = bus.bus_rdata;
                        w_if_done   = 1'b1;
                    end
                end else if (r_cnt == LAST_WAIT) begin
                    w_bus_req = 1'b0;
                    w_bus_err = 1'b1;
                    w_state   = S_DONE;
                    if (r_state == S_MEM_BUS) begin
                        w_mem_rdata = '0;
                        w_mem_done  = 1'b1;
                    end else begin
                        w_if_rdata  = '0;
                        w_if_done   = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_cnt   = '0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_last_mem  <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_last_mem  <= w_last_mem;
            r_bus_req   <= w_bus_req;
            r_bus_we    <= w_bus_we;
            r_bus_sel   <= w_bus_sel;
            r_bus_addr  <= w_bus_addr;
            r_bus_wdata <= w_bus_wdata;
            r_if_rdata  <= w_if_rdata;
            r_mem_rdata <= w_mem_rdata;
            r_if_done   <= w_if_done;
            r_mem_done  <= w_mem_done;
            r_bus_err   <= w_bus_err;
        end
    end

    // Stall drops in the done cycle so the stage advances on the following edge.
    assign bus.if_stallreq  = bus.if_req  & ~r_if_done;
    assign bus.mem_stallreq = bus.mem_req & ~r_mem_done;

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_sel   = r_bus_sel;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.bus_err   = r_bus_err;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_done   = r_if_done;
    assign bus.mem_rdata = r_mem_rdata;
    assign bus.mem_done  = r_mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected grants and
// completions; a monitor pops and compares whenever the bus is granted or a done pulses.
module tb_mem_bus_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 3;

    typedef struct packed {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct packed {
        logic          mem;
        logic [DW-1:0] rdata;
        logic          err;
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    grant_t        gq[$];
    done_t         dq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc   = 0;
    int            ack_delay = 1;
    logic [DW-1:0] ack_data  = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // which: 0 = fetch done, 1 = mem done, 2 = either; also counts cycles with bus_req high
    task automatic wait_done(input int which, output int at, output int nreq);
        at   = -1;
        nreq = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bif.bus_req) nreq++;
            if ((which != 0 && bif.mem_done) || (which != 1 && bif.if_done)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) flag("wait_done", $sformatf("no done pulse within 40 cycles (which=%0d)", which));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, 128'({bif.bus_req, bif.bus_we, bif.bus_sel, bif.if_done, bif.mem_done, bif.bus_err}), 128'(0));
        chk({tag, "_data"}, 128'({bif.bus_addr, bif.bus_wdata, bif.if_rdata, bif.mem_rdata}), 128'(0));
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Bus slave model: acks on bus cycle number ack_delay (0 = never acks).
    initial begin
        int idx;
        idx = 0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst && bif.bus_req) begin
                idx++;
                if (ack_delay != 0 && idx == ack_delay) begin
                    bif.bus_ack   = 1'b1;
                    bif.bus_rdata = ack_data;
                end else begin
                    bif.bus_ack   = 1'b0;
                    bif.bus_rdata = 32'hFFFF_FFFF;
                end
            end else begin
                idx = 0;
                bif.bus_ack   = 1'b0;
                bif.bus_rdata = '0;
            end
        end
    end

    // Monitor: compares each new grant and each completion against the scoreboard.
    initial begin
        logic   prev_req;
        grant_t g;
        done_t  d;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bif.bus_req && !prev_req) begin
                    if (gq.size() == 0) flag("grant", $sformatf("unexpected grant addr=%0h", bif.bus_addr));
                    else begin
                        g = gq.pop_front();
                        chk("grant", 128'({bif.bus_we, bif.bus_sel, bif.bus_addr, bif.bus_wdata}), 128'(g));
                    end
                end
                if (bif.if_done || bif.mem_done) begin
                    if (dq.size() == 0) flag("done", "unexpected done pulse");
                    else begin
                        d = dq.pop_front();
                        chk("done", 128'({bif.mem_done, bif.if_done,
                                          bif.mem_done ? bif.mem_rdata : bif.if_rdata, bif.bus_err}),
                                    128'({d.mem, ~d.mem, d.rdata, d.err}));
                    end
                end else if (bif.bus_err) begin
                    flag("bus_err", "bus_err without a done pulse");
                end
            end
            prev_req = rst ? bif.bus_req : 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, at, nreq, last_at;
        bif.if_req    = 1'b0;
        bif.if_addr   = '0;
        bif.mem_req   = 1'b0;
        bif.mem_we    = 1'b0;
        bif.mem_sel   = '0;
        bif.mem_addr  = '0;
        bif.mem_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Fetch only, ack on the 2nd bus cycle
        ack_delay = 2;
        ack_data  = 32'h2402_0005;
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h100, wdata: 32'h0});
        dq.push_back('{mem: 1'b0, rdata: 32'h2402_0005, err: 1'b0});
        bif.if_addr = 32'h100;
        bif.if_req  = 1'b1;
        start = cyc;
        #1 chk("t1_stall_start", 128'(bif.if_stallreq), 128'(1));
        wait_done(0, at, nreq);
        chk("t1_latency", 128'(at - start), 128'(3));
        chk("t1_stall_done", 128'(bif.if_stallreq), 128'(0));
        bif.if_req = 1'b0;
        @(negedge clk);
        chk("t1_single_pulse", 128'(bif.if_done), 128'(0));

        // Store with immediate ack
        @(negedge clk);
        ack_delay = 1;
        ack_data  = 32'h5555_AAAA;
        gq.push_back('{we: 1'b1, sel: 4'b0011, addr: 32'h80, wdata: 32'hDEAD_BEEF});
        dq.push_back('{mem: 1'b1, rdata: 32'h5555_AAAA, err: 1'b0});
        bif.mem_we    = 1'b1;
        bif.mem_sel   = 4'b0011;
        bif.mem_addr  = 32'h80;
        bif.mem_wdata = 32'hDEAD_BEEF;
        bif.mem_req   = 1'b1;
        start = cyc;
        #1 chk("t2_stalls_start", 128'({bif.if_stallreq, bif.mem_stallreq}), 128'(2'b01));
        wait_done(1, at, nreq);
        chk("t2_latency", 128'(at - start), 128'(2));
        chk("t2_stall_done", 128'({bif.if_stallreq, bif.mem_stallreq}), 128'(2'b00));
        bif.mem_req = 1'b0;

        // Contention from reset release: MEM, IF, MEM, IF
        @(negedge clk);
        rst = 1'b0;
        bif.if_addr   = 32'h200;
        bif.if_req    = 1'b1;
        bif.mem_we    = 1'b0;
        bif.mem_sel   = 4'hF;
        bif.mem_addr  = 32'h300;
        bif.mem_wdata = 32'h0;
        bif.mem_req   = 1'b1;
        ack_delay = 1;
        ack_data  = 32'h0BAD_F00D;
        for (int i = 0; i < 4; i++) begin
            gq.push_back('{we: 1'b0, sel: 4'hF, addr: (i % 2 == 0) ? 32'h300 : 32'h200, wdata: 32'h0});
            dq.push_back('{mem: (i % 2 == 0), rdata: 32'h0BAD_F00D, err: 1'b0});
        end
        #1 chk_reset_outs("reset2");
        @(negedge clk);
        rst = 1'b1;
        last_at = 0;
        for (int i = 0; i < 4; i++) begin
            wait_done(2, at, nreq);
            if (i > 0) chk($sformatf("t3_gap%0d", i), 128'((at - last_at) >= 2), 128'(1));
            last_at = at;
        end
        bif.if_req  = 1'b0;
        bif.mem_req = 1'b0;

        // Timeout: load with no ack
        repeat (2) @(negedge clk);
        ack_delay = 0;
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h40, wdata: 32'h1111_1111});
        dq.push_back('{mem: 1'b1, rdata: 32'h0, err: 1'b1});
        bif.mem_addr  = 32'h40;
        bif.mem_wdata = 32'h1111_1111;
        bif.mem_req   = 1'b1;
        wait_done(1, at, nreq);
        chk("t4_req_cycles", 128'(nreq), 128'(3));
        bif.mem_req = 1'b0;
        @(negedge clk);
        chk("t4_back_idle", 128'({bif.bus_req, bif.bus_err, bif.mem_done}), 128'(0));

        // Ack on the timeout cycle counts as success
        @(negedge clk);
        ack_delay = 3;
        ack_data  = 32'h1234;
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h44, wdata: 32'h1111_1111});
        dq.push_back('{mem: 1'b1, rdata: 32'h1234, err: 1'b0});
        bif.mem_addr = 32'h44;
        bif.mem_req  = 1'b1;
        wait_done(1, at, nreq);
        chk("t5_req_cycles", 128'(nreq), 128'(3));
        bif.mem_req = 1'b0;

        // Reset mid-access, then a tie after release goes to MEM
        repeat (2) @(negedge clk);
        ack_delay = 0;
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h48, wdata: 32'h1111_1111});
        bif.mem_addr = 32'h48;
        bif.mem_req  = 1'b1;
        at = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bif.bus_req) begin
                at = k;
                break;
            end
        end
        if (at < 0) flag("t6_grant", "bus_req never rose");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("t6_req_drop", 128'(bif.bus_req), 128'(0));
        chk_reset_outs("t6_reset");
        bif.mem_req = 1'b0;
        repeat (2) @(negedge clk);
        ack_delay = 1;
        ack_data  = 32'hCAFE_0001;
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h310, wdata: 32'h1111_1111});
        dq.push_back('{mem: 1'b1, rdata: 32'hCAFE_0001, err: 1'b0});
        gq.push_back('{we: 1'b0, sel: 4'hF, addr: 32'h210, wdata: 32'h0});
        dq.push_back('{mem: 1'b0, rdata: 32'hCAFE_0001, err: 1'b0});
        bif.if_addr  = 32'h210;
        bif.if_req   = 1'b1;
        bif.mem_addr = 32'h310;
        bif.mem_req  = 1'b1;
        rst = 1'b1;
        wait_done(1, at, nreq);
        bif.mem_req = 1'b0;
        wait_done(0, at, nreq);
        bif.if_req = 1'b0;

        repeat (5) @(negedge clk);
        chk("queues_empty", 128'(gq.size() + dq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
